// File: rtl/mem_bus_pkg.sv
// Shared encodings for the data-memory access path.
package mem_bus_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_R = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  // Natural alignment check; the reserved size is never aligned.
  function automatic logic is_aligned(logic [1:0] size, logic [1:0] offset);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~offset[0];
      SIZE_W:  ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a bus read word.
module lsu_load_align
  import mem_bus_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    lane_b = word[8*offset +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  data = {{24{sext & lane_b[7]}}, lane_b};
      SIZE_H:  data = {{16{sext & lane_h[15]}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one req/ack bus transaction per op, with stall,
// misalignment detection and a bus timeout.
module mem_access_unit
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [1:0]  op_size,
  input  logic        op_sext,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic        op_done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [TO_W-1:0] CntMax = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            addr_err_q, addr_err_d;
  logic            bus_err_q, bus_err_d;

  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_data;

  // op_addr/op_size/op_sext are held until op_done, so the live inputs steer the load lanes.
  lsu_load_align u_load_align (
    .word   (bus_rdata),
    .offset (op_addr[1:0]),
    .size   (op_size),
    .sext   (op_sext),
    .data   (ld_data)
  );

  // Store byte enables and lane replication.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = op_wdata;
    case (op_size)
      SIZE_B: begin
        st_be    = 4'b0001 << op_addr[1:0];
        st_wdata = {4{op_wdata[7:0]}};
      end
      SIZE_H: begin
        st_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{op_wdata[15:0]}};
      end
      SIZE_W:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Next-state logic: issue, wait for ack or timeout, one-cycle done.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (op_valid) begin
          if (is_aligned(op_size, op_addr[1:0])) begin
            bus_req_d   = 1'b1;
            bus_we_d    = op_we;
            bus_addr_d  = {op_addr[31:2], 2'b00};
            bus_be_d    = op_we ? st_be : 4'b1111;
            bus_wdata_d = op_we ? st_wdata : 32'h0;
            state_d     = StBusy;
          end else begin
            addr_err_d = 1'b1;
            state_d    = StDone;
          end
        end
      end
      StBusy: begin
        // Ack takes priority over a timeout in the same cycle.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = ld_data;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StDone: begin
        // op_valid still belongs to the finished op here.
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Pipeline handshake decoded from state.
  always_comb begin
    stall   = ((state_q == StIdle) && op_valid) || (state_q == StBusy);
    op_done = (state_q == StDone);
  end

  assign rdata     = rdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops
// against a byte-level reference model.
module tb_mem_access_unit;

  localparam int Timeout = 16;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_sext;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic        op_done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_unit #(
    .TIMEOUT (Timeout),
    .TO_W    (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_we     (op_we),
    .op_size   (op_size),
    .op_sext   (op_sext),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .stall     (stall),
    .op_done   (op_done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: number of bytes and natural alignment.
  function automatic bit ref_aligned(logic [1:0] size, logic [31:0] addr);
    int nb;
    if (size == 2'b11) return 1'b0;
    nb = 1 << size;
    return (addr % nb) == 0;
  endfunction

  function automatic logic [3:0] ref_be(logic we, logic [1:0] size, logic [31:0] addr);
    int nb;
    if (!we) return 4'hf;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << addr[1:0]);
  endfunction

  // Each lane carries the byte of the store value that it would hold if replicated.
  function automatic logic [31:0] ref_wdata(logic we, logic [1:0] size, logic [31:0] wdata);
    logic [31:0] r;
    int nb;
    if (!we) return 32'h0;
    nb = 1 << size;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] size, logic sext, logic [31:0] addr,
                                           logic [31:0] word);
    logic [31:0] sh, mask, v;
    int bits;
    if (size == 2'b10) return word;
    bits = 8 << size;
    sh   = word >> (8 * addr[1:0]);
    mask = (32'h1 << bits) - 32'h1;
    v    = sh & mask;
    if (sext && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete op. ack_at = BUSY cycle (1-based) on which ack is given; 0 = never.
  task automatic run_op(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rword);
    bit ok, exp_berr, done;
    int req_cnt, stall_cnt, exp_req;
    ok       = ref_aligned(size, addr);
    exp_berr = ok && !(ack_at >= 1 && ack_at <= Timeout);
    exp_req  = !ok ? 0 : (exp_berr ? Timeout : ack_at);
    op_we    = we;
    op_size  = size;
    op_sext  = sext;
    op_addr  = addr;
    op_wdata = wdata;
    op_valid = 1'b1;
    #1;
    check_val("stall_issue", 32'(stall), 32'd1);
    stall_cnt = 1;
    req_cnt   = 0;
    done      = 1'b0;
    for (int c = 0; c < 3 * Timeout && !done; c++) begin
      @(posedge clk);
      #1;
      if (op_done) begin
        done = 1'b1;
      end else begin
        if (stall) stall_cnt++;
        bus_ack = 1'b0;
        if (bus_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            check_val("bus_addr", bus_addr, {addr[31:2], 2'b00});
            check_val("bus_we", 32'(bus_we), 32'(we));
            check_val("bus_be", 32'(bus_be), 32'(ref_be(we, size, addr)));
            check_val("bus_wdata", bus_wdata, ref_wdata(we, size, wdata));
          end
          if (req_cnt == ack_at) begin
            bus_ack   = 1'b1;
            bus_rdata = rword;
          end else begin
            bus_rdata = $urandom;
          end
        end
      end
    end
    check_val("done_seen", 32'(op_done), 32'd1);
    check_val("req_cycles", 32'(req_cnt), 32'(exp_req));
    check_val("stall_cycles", 32'(stall_cnt), 32'(1 + exp_req));
    check_val("stall_done", 32'(stall), 32'd0);
    check_val("addr_err", 32'(addr_err), 32'(!ok));
    check_val("bus_err", 32'(bus_err), 32'(exp_berr));
    check_val("req_dropped", 32'(bus_req), 32'd0);
    if (ok && !we && !exp_berr) exp_rdata = ref_load(size, sext, addr, rword);
    check_val("rdata", rdata, exp_rdata);
    bus_ack  = 1'b0;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("done_pulse", 32'(op_done), 32'd0);
    check_val("err_clear", 32'({addr_err, bus_err}), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          ack;
    reset     = 1'b0;
    op_valid  = 1'b0;
    op_we     = 1'b0;
    op_size   = 2'b00;
    op_sext   = 1'b0;
    op_addr   = 32'h0;
    op_wdata  = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req", 32'(bus_req), 32'd0);
    check_val("rst_done", 32'(op_done), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_errs", 32'({addr_err, bus_err}), 32'd0);
    check_val("rst_bus", {bus_addr[27:0], bus_be}, 32'h0);
    check_val("rst_wdata", bus_wdata, 32'h0);
    check_val("rst_we", 32'(bus_we), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 3, 32'h0);
    run_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000ab, 1, 32'h0);
    run_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1, 32'h80ff7f01);
    run_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 2, 32'h80ff7f01);
    run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1, 32'h80ff7f01);
    run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 4, 32'h80ff7f01);
    run_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 32'hdeadbeef);
    run_op(1'b1, 2'b11, 1'b0, 32'h20, 32'h55, 1, 32'h0);
    run_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hcafef00d, 0, 32'h0);
    run_op(1'b1, 2'b10, 1'b0, 32'h44, 32'hcafef00d, Timeout, 32'h0);
    run_op(1'b0, 2'b10, 1'b1, 32'h48, 32'h0, Timeout, 32'h8000_0001);

    // Ack while idle must not start or finish anything.
    bus_ack = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_ack_done", 32'(op_done), 32'd0);
    check_val("idle_ack_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_ack_done2", 32'(op_done), 32'd0);

    // Randomized ops.
    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 9) < 7 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
      ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      if ($urandom_range(0, 19) == 0) ack = Timeout;
      run_op(1'($urandom), sz, 1'($urandom), a, $urandom, ack, $urandom);
    end

    // Reset in the middle of a bus cycle.
    op_we    = 1'b1;
    op_size  = 2'b10;
    op_sext  = 1'b0;
    op_addr  = 32'h20;
    op_wdata = 32'h0badf00d;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    check_val("pre_rst_req", 32'(bus_req), 32'd1);
    @(posedge clk);
    #2;
    reset    = 1'b0;
    op_valid = 1'b0;
    #1;
    check_val("async_rst_req", 32'(bus_req), 32'd0);
    check_val("async_rst_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_no_done", 32'(op_done), 32'd0);
    end
    reset     = 1'b1;
    exp_rdata = 32'h0;
    @(posedge clk);
    #1;
    check_val("post_rst_done", 32'(op_done), 32'd0);
    check_val("post_rst_rdata", rdata, 32'h0);
    run_op(1'b1, 2'b10, 1'b0, 32'h24, 32'h600dcafe, 2, 32'h0);
    run_op(1'b0, 2'b01, 1'b1, 32'h26, 32'h0, 1, 32'h9abc1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
